xbus_master_arbiter: RTL and testbench

Two-master arbiter for the shared X bus that sits between the I/D arbiter's X-side output and the ROM/decode slaves. Master A is the CPU-side arbiter. Master B is a second bus master, such as a DMA or video fetch unit. The block grants the X bus round-robin and holds ownership for the whole cycle (cyc). It also runs a watchdog that terminates stalled strobes with an error pulse.

---
 rtl/xbus_master_arbiter.sv | 92 +++++++++
 tb/tb_xbus_master_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/xbus_master_arbiter.sv
// xbus_master_arbiter: two-master round-robin X bus arbiter with cycle-hold ownership and stalled-strobe watchdog
module xbus_master_arbiter #(
  parameter int TW      = 8,
  parameter int TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [63:0] a_adr_i,
  input  logic [63:0] a_dat_i,
  input  logic        a_we_i,
  input  logic        a_cyc_i,
  input  logic        a_stb_i,
  input  logic [1:0]  a_siz_i,
  input  logic        a_signed_i,
  output logic        a_ack_o,
  output logic        a_err_o,
  output logic [63:0] a_dat_o,
  input  logic [63:0] b_adr_i,
  input  logic [63:0] b_dat_i,
  input  logic        b_we_i,
  input  logic        b_cyc_i,
  input  logic        b_stb_i,
  input  logic [1:0]  b_siz_i,
  input  logic        b_signed_i,
  output logic        b_ack_o,
  output logic        b_err_o,
  output logic [63:0] b_dat_o,
  output logic [63:0] x_adr_o,
  output logic [63:0] x_dat_o,
  output logic        x_we_o,
  output logic        x_cyc_o,
  output logic        x_stb_o,
  output logic [1:0]  x_siz_o,
  output logic        x_signed_o,
  input  logic        x_ack_i,
  input  logic [63:0] x_dat_i,
  output logic [1:0]  gnt_o
);
  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;
  localparam logic [TW-1:0] TO = TIMEOUT[TW-1:0];
  state_t        state_q, state_d;
  logic          last_b_q, last_b_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          own_a, own_b, timeout;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      last_b_q <= 1'b1;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      last_b_q <= last_b_d;
      cnt_q    <= cnt_d;
    end
  end
  // A tie in IDLE goes to whichever master did not own the bus last.
  always_comb begin
    state_d  = state_q;
    last_b_d = last_b_q;
    case (state_q)
      IDLE:    state_d = (a_cyc_i && (!b_cyc_i || last_b_q)) ? OWN_A : b_cyc_i ? OWN_B : IDLE;
      OWN_A: if (!a_cyc_i) begin
        state_d  = b_cyc_i ? OWN_B : IDLE;
        last_b_d = 1'b0;
      end
      OWN_B: if (!b_cyc_i) begin
        state_d  = a_cyc_i ? OWN_A : IDLE;
        last_b_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  assign own_a = (state_q == OWN_A);
  assign own_b = (state_q == OWN_B);
  assign gnt_o = {own_b, own_a};
  assign x_cyc_o    = (own_a & a_cyc_i) | (own_b & b_cyc_i);
  assign x_stb_o    = (own_a & a_cyc_i & a_stb_i) | (own_b & b_cyc_i & b_stb_i);
  assign x_adr_o    = own_a ? a_adr_i : own_b ? b_adr_i : 64'h0;
  assign x_dat_o    = own_a ? a_dat_i : own_b ? b_dat_i : 64'h0;
  assign x_we_o     = own_a ? a_we_i : own_b ? b_we_i : 1'b0;
  assign x_siz_o    = own_a ? a_siz_i : own_b ? b_siz_i : 2'b0;
  assign x_signed_o = own_a ? a_signed_i : own_b ? b_signed_i : 1'b0;
  // An ack arriving in the timeout cycle suppresses the error; err itself restarts the count.
  assign timeout = x_stb_o && !x_ack_i && (cnt_q == TO);
  assign cnt_d   = (!x_stb_o || x_ack_i || timeout) ? '0 : cnt_q + 1'b1;
  assign a_ack_o = own_a & x_ack_i;
  assign b_ack_o = own_b & x_ack_i;
  assign a_err_o = own_a & timeout;
  assign b_err_o = own_b & timeout;
  assign a_dat_o = own_a ? x_dat_i : 64'h0;
  assign b_dat_o = own_b ? x_dat_i : 64'h0;
endmodule

// File: tb/tb_xbus_master_arbiter.sv
// tb_xbus_master_arbiter: directed and random checks of xbus_master_arbiter against an ownership/stall model
module tb_xbus_master_arbiter;
  localparam int TO = 4;
  logic clk = 1'b0, reset;
  logic [63:0] a_adr, a_dat, b_adr, b_dat, x_dat, a_dat_o, b_dat_o, x_adr_o, x_dat_o;
  logic a_we, a_cyc, a_stb, a_signed, b_we, b_cyc, b_stb, b_signed, x_ack;
  logic [1:0] a_siz, b_siz, x_siz_o, gnt_o;
  logic a_ack_o, a_err_o, b_ack_o, b_err_o, x_we_o, x_cyc_o, x_stb_o, x_signed_o;
  int n_chk = 0, n_fail = 0;
  int m_own, m_last, m_stall;
  always #5 clk = ~clk;
  xbus_master_arbiter #(.TW(8), .TIMEOUT(TO)) dut (
    .clk_i(clk), .reset_i(reset),
    .a_adr_i(a_adr), .a_dat_i(a_dat), .a_we_i(a_we), .a_cyc_i(a_cyc), .a_stb_i(a_stb),
    .a_siz_i(a_siz), .a_signed_i(a_signed), .a_ack_o(a_ack_o), .a_err_o(a_err_o), .a_dat_o(a_dat_o),
    .b_adr_i(b_adr), .b_dat_i(b_dat), .b_we_i(b_we), .b_cyc_i(b_cyc), .b_stb_i(b_stb),
    .b_siz_i(b_siz), .b_signed_i(b_signed), .b_ack_o(b_ack_o), .b_err_o(b_err_o), .b_dat_o(b_dat_o),
    .x_adr_o(x_adr_o), .x_dat_o(x_dat_o), .x_we_o(x_we_o), .x_cyc_o(x_cyc_o), .x_stb_o(x_stb_o),
    .x_siz_o(x_siz_o), .x_signed_o(x_signed_o), .x_ack_i(x_ack), .x_dat_i(x_dat), .gnt_o(gnt_o)
  );
  logic [267:0] obs;
  assign obs = {gnt_o, x_cyc_o, x_stb_o, x_we_o, x_siz_o, x_signed_o, x_adr_o, x_dat_o,
                a_ack_o, a_err_o, b_ack_o, b_err_o, a_dat_o, b_dat_o};
  // Model: m_own 0 = nobody, 1 = A, 2 = B; m_stall = unanswered strobe cycles since last ack/err.
  function automatic logic owner_stb();
    return (m_own == 1 && a_cyc && a_stb) || (m_own == 2 && b_cyc && b_stb);
  endfunction
  always @(posedge clk) begin
    if (reset) begin
      m_own   <= 0;
      m_last  <= 2;
      m_stall <= 0;
    end else begin
      m_stall <= (owner_stb() && !x_ack && m_stall < TO) ? m_stall + 1 : 0;
      if (m_own == 0)
        m_own <= (a_cyc && b_cyc) ? 3 - m_last : a_cyc ? 1 : b_cyc ? 2 : 0;
      else if (!(m_own == 1 ? a_cyc : b_cyc)) begin
        m_last <= m_own;
        m_own  <= (m_own == 1 ? b_cyc : a_cyc) ? 3 - m_own : 0;
      end
    end
  end
  function automatic logic [267:0] expv();
    logic oa, ob, st, er;
    oa = (m_own == 1);
    ob = (m_own == 2);
    st = owner_stb();
    er = st && !x_ack && m_stall == TO;
    return {ob, oa, (oa & a_cyc) | (ob & b_cyc), st, oa ? a_we : ob ? b_we : 1'b0,
            oa ? a_siz : ob ? b_siz : 2'b0, oa ? a_signed : ob ? b_signed : 1'b0,
            oa ? a_adr : ob ? b_adr : 64'h0, oa ? a_dat : ob ? b_dat : 64'h0,
            oa & x_ack, oa & er, ob & x_ack, ob & er, oa ? x_dat : 64'h0, ob ? x_dat : 64'h0};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_inputs();
    {a_adr, a_dat, b_adr, b_dat, x_dat} = '0;
    {a_we, a_cyc, a_stb, a_signed, b_we, b_cyc, b_stb, b_signed, x_ack, a_siz, b_siz} = '0;
  endtask
  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    a_cyc = 1'b1; a_stb = 1'b1; b_cyc = 1'b1; b_stb = 1'b1; x_ack = 1'b1;
    a_adr = {$urandom, $urandom}; b_adr = {$urandom, $urandom}; x_dat = {$urandom, $urandom};
    tick();
    tick();
    @(negedge clk);
    n_chk++;
    if (obs !== 268'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0", obs);
    end
    tick();
    do_reset();
  endtask
  task automatic test_single_a();
    int acks = 0, backs = 0;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      a_cyc = (i < 5); a_stb = (i < 5); a_adr = 64'h1000; a_we = 1'b1; a_siz = 2'd3;
      a_dat = {$urandom, $urandom}; x_dat = {$urandom, $urandom}; x_ack = (i == 3);
      @(negedge clk);
      n_chk++;
      if (obs !== expv()) begin
        n_fail++;
        $display("FAIL single_a cyc %0d: got %h required %h", i, obs, expv());
      end
      if (i == 1) begin
        n_chk++;
        if (gnt_o !== 2'b01 || x_adr_o !== 64'h1000) begin
          n_fail++;
          $display("FAIL single_a_grant: gnt %b adr %h required 01 1000", gnt_o, x_adr_o);
        end
      end
      acks += a_ack_o;
      backs += b_ack_o;
      tick();
    end
    n_chk++;
    if (acks != 1 || backs != 0) begin
      n_fail++;
      $display("FAIL single_a_acks: a %0d b %0d required 1 0", acks, backs);
    end
    idle_inputs();
  endtask
  task automatic test_back_to_back();
    logic [1:0] gnt_seq [12];
    logic [1:0] req_seq [12];
    do_reset();
    for (int i = 0; i < 12; i++) begin
      a_cyc = (i < 4) || (i >= 8); b_cyc = (i < 7) || (i >= 8);
      a_stb = 1'b1; b_stb = 1'b1; a_adr = 64'hA000 + i; b_adr = 64'hB000 + i;
      @(negedge clk);
      n_chk++;
      if (obs !== expv()) begin
        n_fail++;
        $display("FAIL back_to_back cyc %0d: got %h required %h", i, obs, expv());
      end
      gnt_seq[i] = gnt_o;
      tick();
    end
    req_seq = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b01};
    for (int i = 0; i < 12; i++) begin
      n_chk++;
      if (gnt_seq[i] !== req_seq[i]) begin
        n_fail++;
        $display("FAIL back_to_back_gnt cyc %0d: got %b required %b", i, gnt_seq[i], req_seq[i]);
      end
    end
    idle_inputs();
  endtask
  task automatic test_fairness();
    do_reset();
    b_cyc = 1'b1; b_stb = 1'b1; b_adr = 64'hBBBB_0000;
    for (int i = 0; i < 13; i++) begin
      a_cyc = (i < 11); a_stb = 1'b1; a_adr = {32'h0, $urandom};
      x_ack = $urandom_range(1); x_dat = {$urandom, $urandom};
      @(negedge clk);
      n_chk++;
      if (obs !== expv()) begin
        n_fail++;
        $display("FAIL fairness cyc %0d: got %h required %h", i, obs, expv());
      end
      if (i >= 1 && i <= 10) begin
        n_chk++;
        if (gnt_o !== 2'b01 || x_adr_o !== a_adr || b_ack_o !== 1'b0) begin
          n_fail++;
          $display("FAIL fairness_hold cyc %0d: gnt %b adr %h back %b", i, gnt_o, x_adr_o, b_ack_o);
        end
      end
      if (i == 12) begin
        n_chk++;
        if (gnt_o !== 2'b10) begin
          n_fail++;
          $display("FAIL fairness_handover: gnt %b required 10", gnt_o);
        end
      end
      tick();
    end
    idle_inputs();
  endtask
  task automatic test_watchdog();
    int errs = 0;
    do_reset();
    a_cyc = 1'b1; a_stb = 1'b1; a_adr = 64'h2000;
    tick();
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      n_chk++;
      if (a_err_o !== (k == 4 || k == 9) || gnt_o !== 2'b01) begin
        n_fail++;
        $display("FAIL watchdog k %0d: err %b gnt %b required err %b gnt 01", k, a_err_o, gnt_o, k == 4 || k == 9);
      end
      errs += a_err_o;
      tick();
    end
    n_chk++;
    if (errs != 2) begin
      n_fail++;
      $display("FAIL watchdog_count: got %0d required 2", errs);
    end
    idle_inputs();
  endtask
  task automatic test_ack_timeout();
    do_reset();
    a_cyc = 1'b1; a_stb = 1'b1;
    tick();
    for (int k = 0; k < 10; k++) begin
      x_ack = (k == 4);
      @(negedge clk);
      n_chk++;
      if (a_ack_o !== (k == 4) || a_err_o !== (k == 9)) begin
        n_fail++;
        $display("FAIL ack_timeout k %0d: ack %b err %b required %b %b", k, a_ack_o, a_err_o, k == 4, k == 9);
      end
      tick();
    end
    idle_inputs();
  endtask
  task automatic test_reset_mid();
    do_reset();
    b_cyc = 1'b1; b_stb = 1'b1; b_adr = 64'h3000;
    tick();
    tick();
    x_ack = 1'b1;
    reset = 1'b1;
    tick();
    @(negedge clk);
    n_chk++;
    if (gnt_o !== 2'b00 || x_stb_o !== 1'b0 || b_ack_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: gnt %b stb %b back %b required 00 0 0", gnt_o, x_stb_o, b_ack_o);
    end
    reset = 1'b0;
    idle_inputs();
    tick();
  endtask
  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(5) == 0) a_cyc = ~a_cyc;
      if ($urandom_range(5) == 0) b_cyc = ~b_cyc;
      a_stb = ($urandom_range(3) != 0); b_stb = ($urandom_range(3) != 0);
      x_ack = ($urandom_range(5) == 0); reset = ($urandom_range(299) == 0);
      a_adr = {$urandom, $urandom}; a_dat = {$urandom, $urandom}; b_adr = {$urandom, $urandom};
      b_dat = {$urandom, $urandom}; x_dat = {$urandom, $urandom};
      {a_we, a_signed, a_siz, b_we, b_signed, b_siz} = 8'($urandom);
      @(negedge clk);
      n_chk++;
      if (obs !== expv()) begin
        n_fail++;
        $display("FAIL random cyc %0d: got %h required %h", i, obs, expv());
      end
      tick();
    end
    reset = 1'b0;
    idle_inputs();
  endtask
  initial begin
    idle_inputs();
    reset = 1'b1;
    #1;
    test_reset();
    test_single_a();
    test_back_to_back();
    test_fairness();
    test_watchdog();
    test_ack_timeout();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
